// File: rtl/aes_pkg.sv
// Shared types and constants for the CBC-mode AES-256 decrypt wrapper.
package aes_pkg;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int unsigned CNT_W    = 32;
    localparam int unsigned SETTLE_W = 4;

endpackage

// File: rtl/aes_cbc_dec_256.sv
// CBC chaining wrapper around an external combinational aes_decrypt_256 core:
// registers ciphertext, waits for the core to settle, XORs with the chaining value.
module aes_cbc_dec_256
    import aes_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iv_load,
    input  logic [127:0]     iv,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_block,
    output logic [127:0]     dec_cipher,
    input  logic [127:0]     dec_plain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_block,
    output logic [CNT_W-1:0] blk_count,
    output logic             busy
);

    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t              r_state;
    state_t              w_next;
    block_t              r_chain;
    block_t              r_cipher;
    block_t              r_out_block;
    logic                r_out_valid;
    logic [CNT_W-1:0]    r_blk_count;
    logic [SETTLE_W-1:0] r_settle;

    logic w_accept;
    logic w_capture;
    logic w_release;
    logic w_iv_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_release = 1'b0;
        w_iv_load = 1'b0;
        in_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready  = ~iv_load;
                w_iv_load = iv_load;
                if (!iv_load && in_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_settle == '0) begin
                    w_capture = 1'b1;
                    w_next    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_release = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain     <= '0;
            r_cipher    <= '0;
            r_out_block <= '0;
            r_out_valid <= 1'b0;
            r_blk_count <= '0;
            r_settle    <= '0;
        end else begin
            if (w_iv_load) begin
                r_chain     <= iv;
                r_blk_count <= '0;
            end
            if (w_accept) begin
                r_cipher <= in_block;
                r_settle <= SETTLE_INIT;
            end else if (r_state == ST_WAIT && r_settle != '0) begin
                r_settle <= r_settle - 1'b1;
            end
            if (w_capture) begin
                r_out_block <= dec_plain ^ r_chain;
                r_out_valid <= 1'b1;
            end
            // The ciphertext just consumed becomes the chaining value for the next block.
            if (w_release) begin
                r_out_valid <= 1'b0;
                r_chain     <= r_cipher;
                r_blk_count <= r_blk_count + 1'b1;
            end
        end
    end

    assign dec_cipher = r_cipher;
    assign out_valid  = r_out_valid;
    assign out_block  = r_out_block;
    assign blk_count  = r_blk_count;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_aes_cbc_dec_256.sv
// Directed bench for aes_cbc_dec_256 with a settling decrypt-core stub and an expected-result queue.
module tb_aes_cbc_dec_256;
    import aes_pkg::*;

    localparam int unsigned SETTLE = 2;
    localparam block_t CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam block_t PT = 128'h00112233445566778899aabbccddeeff;

    typedef struct {
        block_t      blk;
        block_t      cipher;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv_load = 1'b0;
    block_t      iv = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    block_t      in_block = '0;
    block_t      dec_cipher;
    block_t      dec_plain;
    logic        out_valid;
    logic        out_ready = 1'b0;
    block_t      out_block;
    logic [31:0] blk_count;
    logic        busy;

    int unsigned total = 0;
    int unsigned bad = 0;
    exp_t        sb[$];
    block_t      m_chain = '0;
    logic [31:0] m_cnt = '0;

    aes_cbc_dec_256 #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .iv_load(iv_load), .iv(iv),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .dec_cipher(dec_cipher), .dec_plain(dec_plain),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .blk_count(blk_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Core stub: known FIPS-197 vector, otherwise a fixed scramble.
    function automatic block_t core_f(input block_t c);
        if (c == CT) return PT;
        return {c[63:0], c[127:64]} ^ 128'hA5C3_0F96_5A3C_F069_1234_5678_9ABC_DEF0;
    endfunction

    // Output is garbage until SETTLE cycles after dec_cipher changes.
    block_t      r_last = '0;
    int unsigned r_age = 100;
    always @(posedge clk) begin
        if (dec_cipher !== r_last) begin
            r_last <= dec_cipher;
            r_age  <= 0;
        end else if (r_age < 100) begin
            r_age <= r_age + 1;
        end
    end
    always_comb begin
        dec_plain = ~core_f(dec_cipher);
        if (dec_cipher === r_last && r_age + 2 >= SETTLE) dec_plain = core_f(dec_cipher);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_iv(input block_t v);
        iv_load = 1'b1;
        iv      = v;
        @(negedge clk);
        iv_load = 1'b0;
        m_chain = v;
        m_cnt   = '0;
    endtask

    task automatic send(input block_t c, input block_t exp_blk);
        int unsigned k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_before_send", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_block = c;
        sb.push_back('{blk: exp_blk, cipher: c, cnt: m_cnt + 32'd1});
        @(negedge clk);
        in_valid = 1'b0;
        in_block = '0;
    endtask

    task automatic recv(input int unsigned hold, input logic noise);
        int unsigned lat = 0;
        exp_t        e;
        block_t      held;
        chk("busy_after_accept", 128'(busy), 128'd1);
        chk("in_ready_in_wait", 128'(in_ready), 128'd0);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("out_valid_latency", 128'(lat), 128'(SETTLE));
        held = out_block;
        for (int unsigned i = 0; i < hold; i++) begin
            if (noise) begin
                iv_load = 1'b1;
                iv      = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            chk("hold_out_valid", 128'(out_valid), 128'd1);
            chk("hold_out_block", out_block, held);
            chk("hold_in_ready", 128'(in_ready), 128'd0);
        end
        iv_load = 1'b0;
        e = sb.pop_front();
        chk("out_block", out_block, e.blk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_cleared", 128'(out_valid), 128'd0);
        chk("out_block_kept", out_block, e.blk);
        chk("blk_count", 128'(blk_count), 128'(e.cnt));
        chk("busy_idle", 128'(busy), 128'd0);
        m_chain = e.cipher;
        m_cnt   = e.cnt;
    endtask

    initial begin
        block_t r, c;
        #2;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_block", out_block, '0);
        chk("rst_blk_count", 128'(blk_count), 128'd0);
        chk("rst_dec_cipher", dec_cipher, '0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Known vector with IV 0.
        load_iv('0);
        send(CT, PT);
        chk("dec_cipher", dec_cipher, CT);
        recv(0, 1'b0);

        // IV all-ones, long hold with ignored iv_load, then chained second block.
        load_iv('1);
        send(CT, 128'hffeeddccbbaa99887766554433221100);
        recv(5, 1'b1);
        send(CT, 128'h8eb395f9153223c86265e32b87948e76);
        recv(0, 1'b0);
        chk("blk_count_two", 128'(blk_count), 128'd2);

        // iv_load wins over simultaneous in_valid.
        r = {$urandom, $urandom, $urandom, $urandom};
        c = {$urandom, $urandom, $urandom, $urandom};
        iv_load  = 1'b1;
        iv       = r;
        in_valid = 1'b1;
        in_block = c;
        #1;
        chk("in_ready_during_iv_load", 128'(in_ready), 128'd0);
        @(negedge clk);
        iv_load = 1'b0;
        m_chain = r;
        m_cnt   = '0;
        chk("not_accepted_with_iv_load", 128'(busy), 128'd0);
        sb.push_back('{blk: core_f(c) ^ r, cipher: c, cnt: 32'd1});
        @(negedge clk);
        in_valid = 1'b0;
        recv(1, 1'b0);

        // A few chained random blocks.
        for (int unsigned i = 0; i < 3; i++) begin
            c = {$urandom, $urandom, $urandom, $urandom};
            send(c, core_f(c) ^ m_chain);
            recv(i, 1'b0);
        end

        // Reset during WAIT discards the block.
        c = {$urandom, $urandom, $urandom, $urandom};
        send(c, core_f(c) ^ m_chain);
        void'(sb.pop_back());
        #2 rst_n = 1'b0;
        #1;
        chk("wrst_out_valid", 128'(out_valid), 128'd0);
        chk("wrst_out_block", out_block, '0);
        chk("wrst_blk_count", 128'(blk_count), 128'd0);
        chk("wrst_dec_cipher", dec_cipher, '0);
        chk("wrst_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_chain = '0;
        m_cnt   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wrst_no_out_valid", 128'(out_valid), 128'd0);
        end
        chk("wrst_in_ready", 128'(in_ready), 128'd1);
        send(CT, PT);
        recv(0, 1'b0);

        // Counter wrap.
        force dut.r_blk_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_blk_count;
        m_cnt = 32'hFFFF_FFFF;
        c = {$urandom, $urandom, $urandom, $urandom};
        send(c, core_f(c) ^ m_chain);
        recv(0, 1'b0);
        chk("blk_count_wrap", 128'(blk_count), 128'd0);

        chk("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/aes_cbc_dec_256.md
AES_CBC_DEC_256 -- requirements
Module: aes_cbc_dec_256

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, giving the number of clock cycles allowed for the external combinational decrypt core to settle (legal range 1..15).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 iv_load  input  1  load initialisation vector into chaining register.
REQ-006 iv  input  128  initialisation vector value.
REQ-007 in_valid  input  1  ciphertext block available.
REQ-008 in_ready  output  1  block can accept ciphertext.
REQ-009 in_block  input  128  ciphertext block.
REQ-010 dec_cipher  output  128  registered ciphertext driven to the aes_decrypt_256 cipher input.
REQ-011 dec_plain  input  128  raw plain output returned from aes_decrypt_256.
REQ-012 out_valid  output  1  CBC plaintext valid.
REQ-013 out_ready  input  1  consumer accepts plaintext.
REQ-014 out_block  output  128  CBC plaintext, equal to dec_plain XOR chaining value.
REQ-015 blk_count  output  32  blocks delivered since the last iv_load or reset.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have three states, IDLE, WAIT and HOLD, with no other reachable states.
REQ-018 In IDLE, in_ready SHALL be 1 when iv_load is 0 and SHALL be 0 otherwise; in WAIT and HOLD, in_ready SHALL be 0.
REQ-019 When iv_load is 1 in IDLE, the chaining register SHALL load iv and blk_count SHALL clear to 0; iv_load has priority over a simultaneous in_valid.
REQ-020 iv_load SHALL be ignored in WAIT and HOLD.
REQ-021 When in_valid and in_ready are both 1 at an edge, the block SHALL load in_block into the cipher register, load SETTLE_CYCLES-1 into the settle counter, and move IDLE->WAIT.
REQ-022 dec_cipher SHALL always equal the cipher register.
REQ-023 In WAIT, the settle counter SHALL decrement each cycle.
REQ-024 At the edge where the settle counter is 0 in WAIT, out_block SHALL register dec_plain XOR the chaining value, out_valid SHALL become 1, and the state SHALL move to HOLD.
REQ-025 The handshake timing SHALL be: input accepted at the end of cycle N, WAIT occupies cycles N+1..N+SETTLE_CYCLES, and out_valid is first high in cycle N+SETTLE_CYCLES+1.
REQ-026 In HOLD, out_valid and out_block SHALL stay stable until out_ready is 1.
REQ-027 On the HOLD edge with out_ready 1, the block SHALL clear out_valid, load the cipher register into the chaining register, increment blk_count modulo 2^32 (0xFFFFFFFF wraps to 0), and return to IDLE.
REQ-028 A new block SHALL be accepted no earlier than the cycle after the HOLD->IDLE edge, so there is no overlap between blocks.
REQ-029 Maximum throughput SHALL be one block per SETTLE_CYCLES+2 cycles.
REQ-030 out_block SHALL be unchanged when out_valid is 0, holding the last value or 0 after reset.

Reset
REQ-031 When rst_n is 0, the block SHALL immediately force: state IDLE; chaining register, cipher register, out_block and blk_count to 0; settle counter 0; out_valid 0; busy 0.
REQ-032 Reset asserted during WAIT or HOLD SHALL discard the block in flight with no output handshake; after release, in_ready SHALL be 1 (when iv_load is 0) and the chaining value SHALL be 0.

Structure
REQ-033 The shared package aes_pkg SHALL hold the 128-bit block typedef, the FSM state enum, and the counter width constant.
REQ-034 The block SHALL contain no sub-module; aes_decrypt_256 is instantiated beside it by the parent, which ties key and wires dec_cipher/dec_plain.

Verification
REQ-035 Key 000102..1f, IV 0, in_block 8ea2b7ca516745bfeafc49904b496089 -> out_block 00112233445566778899aabbccddeeff, out_valid in cycle N+3 (SETTLE_CYCLES=2).
REQ-036 IV all-ones, same key/cipher -> out_block ffeeddccbbaa99887766554433221100; the same cipher sent as the second block -> out_block 8eb395f9153223c86265e32b87948e76, blk_count 2.
REQ-037 out_ready held 0 for 5 cycles in HOLD -> out_valid and out_block stable, in_ready 0, iv_load ignored (chaining value unchanged).
REQ-038 iv_load and in_valid both 1 in IDLE -> IV loaded, block not accepted, accepted on the next cycle.
REQ-039 rst_n pulsed low in WAIT -> out_valid never rises, all outputs 0, next block decrypts with IV 0.
REQ-040 blk_count preset to 0xFFFFFFFF via 2^32 blocks or a forced register, then one block delivered -> blk_count 0.
